// File: rtl/cache_miss_ctrl.sv
// Miss/writeback sequencer between the two-way data cache and data memory.
// Optional perf counters (miss_count_o, wb_count_o) are enabled by defining MISSCTRL_PERF_EN.
module cache_miss_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cache_miss_i,
  input  logic        cache_write_i,
  input  logic [31:0] req_addr_i,
  input  logic        victim_dirty_i,
  input  logic [31:0] victim_addr_i,
  input  logic [31:0] victim_data_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        fill_en_o,
  output logic [31:0] fill_addr_o,
  output logic [31:0] fill_data_o,
  output logic        fill_dirty_o,
  output logic        err_timeout_o
`ifdef MISSCTRL_PERF_EN
  ,
  output logic [31:0] miss_count_o,
  output logic [31:0] wb_count_o
`endif
);

  typedef enum logic [1:0] {StIdle, StWb, StRefill, StFill} state_e;

  localparam bit              TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               cache_write_q, cache_write_d;
  logic [31:0]        victim_addr_q, victim_addr_d;
  logic [31:0]        victim_data_q, victim_data_d;
  logic [31:0]        fill_data_q, fill_data_d;
  logic               err_q, err_d;
  logic               timeout_hit;

  // The cycle that would bring the wait count up to TIMEOUT_CYCLES aborts, unless data arrives.
  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_addr_d    = req_addr_q;
    cache_write_d = cache_write_q;
    victim_addr_d = victim_addr_q;
    victim_data_d = victim_data_q;
    fill_data_d   = fill_data_q;
    err_d         = err_q;
    unique case (state_q)
      StIdle: begin
        if (cache_miss_i) begin
          req_addr_d    = req_addr_i;
          cache_write_d = cache_write_i;
          victim_addr_d = victim_addr_i;
          victim_data_d = victim_data_i;
          cnt_d         = '0;
          state_d       = victim_dirty_i ? StWb : StRefill;
        end
      end
      StWb: begin
        if (mem_valid_i) begin
          cnt_d   = '0;
          state_d = StRefill;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRefill: begin
        if (mem_valid_i) begin
          fill_data_d = mem_rdata_i;
          state_d     = StFill;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFill: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_addr_q    <= '0;
      cache_write_q <= 1'b0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      fill_data_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_addr_q    <= req_addr_d;
      cache_write_q <= cache_write_d;
      victim_addr_q <= victim_addr_d;
      victim_data_q <= victim_data_d;
      fill_data_q   <= fill_data_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    fill_en_o    = 1'b0;
    fill_addr_o  = '0;
    fill_data_o  = '0;
    fill_dirty_o = 1'b0;
    unique case (state_q)
      StWb: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {victim_addr_q[31:2], 2'b00};
        mem_wdata_o = victim_data_q;
      end
      StRefill: begin
        mem_read_o = 1'b1;
        mem_addr_o = {req_addr_q[31:2], 2'b00};
      end
      StFill: begin
        fill_en_o    = 1'b1;
        fill_addr_o  = req_addr_q;
        fill_data_o  = fill_data_q;
        fill_dirty_o = cache_write_q;
      end
      default: ;
    endcase
  end

  // Stall is combinational so the miss cycle itself freezes the pipe; forced low in reset.
  assign stall_o       = !rst_i && ((state_q != StIdle) || cache_miss_i);
  assign err_timeout_o = err_q;

`ifdef MISSCTRL_PERF_EN
  logic [31:0] miss_count_q, wb_count_q;
  logic        miss_inc, wb_inc;

  assign miss_inc = (state_q == StIdle) && cache_miss_i;
  assign wb_inc   = (state_q == StWb) && mem_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
      if (wb_inc && (wb_count_q != 32'hFFFF_FFFF)) begin
        wb_count_q <= wb_count_q + 32'd1;
      end
    end
  end

  assign miss_count_o = miss_count_q;
  assign wb_count_o   = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Table-driven bench for cache_miss_ctrl, plus hand-written reset sequences.
// Define MISSCTRL_PERF_EN to also check the perf counters.
module tb_cache_miss_ctrl;

  typedef struct packed {
    logic        miss;
    logic        wr;
    logic [31:0] raddr;
    logic        vd;
    logic [31:0] vaddr;
    logic [31:0] vdata;
    logic        mv;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        st;
    logic        fe;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic        fdy;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_miss, cache_write, victim_dirty, mem_valid;
  logic [31:0] req_addr, victim_addr, victim_data, mem_rdata;
  logic        mem_read, mem_write, stall, fill_en, fill_dirty, err_timeout;
  logic [31:0] mem_addr, mem_wdata, fill_addr, fill_data;
`ifdef MISSCTRL_PERF_EN
  logic [31:0] miss_count, wb_count;
`endif

  int nvec  = 0;
  int nfail = 0;

  vec_t  tbl[$];
  string names[$];

  always #5 clk = ~clk;

  cache_miss_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cache_miss_i  (cache_miss),
    .cache_write_i (cache_write),
    .req_addr_i    (req_addr),
    .victim_dirty_i(victim_dirty),
    .victim_addr_i (victim_addr),
    .victim_data_i (victim_data),
    .mem_valid_i   (mem_valid),
    .mem_rdata_i   (mem_rdata),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .stall_o       (stall),
    .fill_en_o     (fill_en),
    .fill_addr_o   (fill_addr),
    .fill_data_o   (fill_data),
    .fill_dirty_o  (fill_dirty),
    .err_timeout_o (err_timeout)
`ifdef MISSCTRL_PERF_EN
    ,
    .miss_count_o  (miss_count),
    .wb_count_o    (wb_count)
`endif
  );

  function automatic in_t mk_in(logic miss, logic wr, logic [31:0] raddr, logic vd,
                                logic [31:0] vaddr, logic [31:0] vdata, logic mv,
                                logic [31:0] rdata);
    in_t r;
    r = '{miss, wr, raddr, vd, vaddr, vdata, mv, rdata};
    return r;
  endfunction

  function automatic out_t mk_out(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                  logic st, logic fe, logic [31:0] faddr, logic [31:0] fdata,
                                  logic fdy, logic err);
    out_t r;
    r = '{rd, wr, addr, wdata, st, fe, faddr, fdata, fdy, err};
    return r;
  endfunction

  // Common expectation shapes; all values still supplied by the caller.
  function automatic out_t o_idle(logic err);
    return mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, err);
  endfunction
  function automatic out_t o_miss(logic err);
    return mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, err);
  endfunction
  function automatic out_t o_rd(logic [31:0] a, logic err);
    return mk_out(1, 0, a, 0, 1, 0, 0, 0, 0, err);
  endfunction
  function automatic out_t o_wb(logic [31:0] a, logic [31:0] d, logic err);
    return mk_out(0, 1, a, d, 1, 0, 0, 0, 0, err);
  endfunction
  function automatic out_t o_fill(logic [31:0] a, logic [31:0] d, logic dy, logic err);
    return mk_out(0, 0, 0, 0, 1, 1, a, d, dy, err);
  endfunction

  function automatic in_t i_none(logic mv, logic [31:0] rdata);
    return mk_in(0, 0, 0, 0, 0, 0, mv, rdata);
  endfunction
  function automatic in_t i_clean(logic [31:0] a, logic mv, logic [31:0] rdata);
    return mk_in(1, 0, a, 0, 0, 0, mv, rdata);
  endfunction

  task automatic add(input string n, input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
    names.push_back(n);
  endtask

  task automatic check_out(input string n, input out_t exp);
    out_t got;
    got = '{mem_read, mem_write, mem_addr, mem_wdata, stall, fill_en, fill_addr, fill_data,
            fill_dirty, err_timeout};
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got rd=%b wr=%b addr=%h wd=%h st=%b fe=%b fa=%h fd=%h fdy=%b err=%b; want rd=%b wr=%b addr=%h wd=%h st=%b fe=%b fa=%h fd=%h fdy=%b err=%b",
               n, got.rd, got.wr, got.addr, got.wdata, got.st, got.fe, got.faddr, got.fdata,
               got.fdy, got.err, exp.rd, exp.wr, exp.addr, exp.wdata, exp.st, exp.fe,
               exp.faddr, exp.fdata, exp.fdy, exp.err);
    end
  endtask

  task automatic check_val(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask

  task automatic drive(input in_t i);
    cache_miss   = i.miss;
    cache_write  = i.wr;
    req_addr     = i.raddr;
    victim_dirty = i.vd;
    victim_addr  = i.vaddr;
    victim_data  = i.vdata;
    mem_valid    = i.mv;
    mem_rdata    = i.rdata;
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later, well before the rising edge.
  task automatic run_seg(input int from, input int to);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      check_out(names[k], tbl[k].o);
    end
  endtask

  int seg2, seg3, seg_end;

  initial begin
    // Clean load miss, mem_valid on the 2nd REFILL cycle; mem_valid ignored in FILL/IDLE.
    add("t1 idle miss",    i_clean(32'h104, 0, 0),             o_miss(0));
    add("t1 refill wait",  i_clean(32'h104, 0, 0),             o_rd(32'h104, 0));
    add("t1 refill done",  i_clean(32'h104, 1, 32'hDEAD_BEEF), o_rd(32'h104, 0));
    add("t1 fill",         i_none(1, 32'h1111_1111),           o_fill(32'h104, 32'hDEAD_BEEF, 0, 0));
    add("t1 idle mv ign",  i_none(1, 32'h2222_2222),           o_idle(0));
    add("t1 idle stay",    i_none(0, 0),                       o_idle(0));
    // Dirty store miss with input churn during WB and REFILL.
    add("t2 idle miss",    mk_in(1, 1, 32'h200, 1, 32'hA08, 32'h1234_5678, 0, 0), o_miss(0));
    add("t2 wb wait",      mk_in(1, 0, 32'hFFFF_FFF0, 0, 32'h0BAD_0000, 32'hBAD0_BAD0, 0, 0),
        o_wb(32'hA08, 32'h1234_5678, 0));
    add("t2 wb done",      mk_in(1, 0, 32'hFFFF_FFF0, 0, 32'h0BAD_0000, 32'hBAD0_BAD0, 1, 0),
        o_wb(32'hA08, 32'h1234_5678, 0));
    add("t2 refill wait",  mk_in(1, 0, 32'hFFFF_FFF0, 1, 32'h0BAD_0000, 32'hBAD0_BAD0, 0, 0),
        o_rd(32'h200, 0));
    add("t2 refill done",  mk_in(1, 0, 32'hFFFF_FFF0, 1, 32'h0BAD_0000, 32'hBAD0_BAD0, 1,
                                 32'hCAFE_F00D), o_rd(32'h200, 0));
    add("t2 fill dirty",   i_none(0, 0), o_fill(32'h200, 32'hCAFE_F00D, 1, 0));
    add("t2 idle",         i_none(0, 0), o_idle(0));
    // Unaligned address; mem_valid on the would-be timeout cycle wins.
    add("race idle miss",  i_clean(32'h402, 0, 0),             o_miss(0));
    add("race refill 1",   i_clean(32'h402, 0, 0),             o_rd(32'h400, 0));
    add("race refill 2",   i_clean(32'h402, 0, 0),             o_rd(32'h400, 0));
    add("race refill 3",   i_clean(32'h402, 0, 0),             o_rd(32'h400, 0));
    add("race refill 4 mv", i_clean(32'h402, 1, 32'h0F0F_0F0F), o_rd(32'h400, 0));
    add("race fill",       i_none(0, 0), o_fill(32'h402, 32'h0F0F_0F0F, 0, 0));
    add("race idle no err", i_none(0, 0), o_idle(0));
    // Timeout after 4 REFILL cycles, abort without fill, retry on the held miss.
    add("t4 idle miss",    i_clean(32'h300, 0, 0), o_miss(0));
    add("t4 refill 1",     i_clean(32'h300, 0, 0), o_rd(32'h300, 0));
    add("t4 refill 2",     i_clean(32'h300, 0, 0), o_rd(32'h300, 0));
    add("t4 refill 3",     i_clean(32'h300, 0, 0), o_rd(32'h300, 0));
    add("t4 refill 4",     i_clean(32'h300, 0, 0), o_rd(32'h300, 0));
    add("t4 abort idle",   i_clean(32'h300, 0, 0), o_miss(1));
    add("t4 retry wait",   i_clean(32'h300, 0, 0), o_rd(32'h300, 1));
    add("t4 retry done",   i_clean(32'h300, 1, 32'h5555_AAAA), o_rd(32'h300, 1));
    add("t4 retry fill",   i_none(0, 0), o_fill(32'h300, 32'h5555_AAAA, 0, 1));
    add("t4 idle sticky",  i_none(0, 0), o_idle(1));
    seg2 = tbl.size();
    // Into REFILL, then reset mid-cycle (hand-written below).
    add("t5 idle miss",    i_clean(32'h500, 0, 0), o_miss(1));
    add("t5 refill",       i_clean(32'h500, 0, 0), o_rd(32'h500, 1));
    seg3 = tbl.size();
    add("t5 idle post rst", i_none(0, 0), o_idle(0));
    add("p clean miss",    i_clean(32'h600, 0, 0),             o_miss(0));
    add("p clean refill",  i_clean(32'h600, 1, 32'h6666_6666), o_rd(32'h600, 0));
    add("p clean fill",    i_none(0, 0), o_fill(32'h600, 32'h6666_6666, 0, 0));
    add("p clean idle",    i_none(0, 0), o_idle(0));
    add("p dirty miss",    mk_in(1, 0, 32'h700, 1, 32'hC00, 32'h7777_7777, 0, 0), o_miss(0));
    add("p dirty wb",      mk_in(1, 0, 32'h700, 1, 32'hC00, 32'h7777_7777, 1, 0),
        o_wb(32'hC00, 32'h7777_7777, 0));
    add("p dirty refill",  i_clean(32'h700, 1, 32'h7070_7070), o_rd(32'h700, 0));
    add("p dirty fill",    i_none(0, 0), o_fill(32'h700, 32'h7070_7070, 0, 0));
    add("p dirty idle",    i_none(0, 0), o_idle(0));
    add("p 3rd miss",      i_clean(32'h800, 0, 0),             o_miss(0));
    add("p 3rd refill",    i_clean(32'h800, 1, 32'h8888_8888), o_rd(32'h800, 0));
    add("p 3rd fill",      i_none(0, 0), o_fill(32'h800, 32'h8888_8888, 0, 0));
    add("p 3rd idle",      i_none(0, 0), o_idle(0));
    seg_end = tbl.size();

    // Reset with a miss pending: stall must still be low.
    rst = 1'b1;
    drive(i_clean(32'h104, 0, 0));
    #3;
    check_out("reset outputs", o_idle(0));
    repeat (2) @(posedge clk);
    #1;
    check_out("reset held", o_idle(0));
    @(negedge clk);
    rst = 1'b0;
    drive(i_none(0, 0));

    run_seg(0, seg2);
    run_seg(seg2, seg3);

    // Asynchronous reset in the middle of REFILL, miss still asserted.
    #2;
    rst = 1'b1;
    #1;
    check_out("t5 rst async", o_idle(0));
    @(posedge clk);
    #1;
    check_out("t5 rst over edge", o_idle(0));
    @(negedge clk);
    rst = 1'b0;
    drive(i_none(0, 0));

    run_seg(seg3, seg_end);

`ifdef MISSCTRL_PERF_EN
    check_val("perf miss_count", miss_count, 32'd3);
    check_val("perf wb_count", wb_count, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
